// File: rtl/axis_stream_pkg.sv
// Shared definitions for stream-path blocks: FSM encoding and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package axis_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_STREAM = STREAM,
        ST_GAP    = GAP,
        ST_DONE   = DONE
    } stream_state_t;

endpackage

// File: rtl/axis_counter_src.sv
// Counting stream source: emits cfg_len beats start_val + k*STEP; optional inter-beat gaps with AXIS_COUNTER_SRC_THROTTLE_EN.
// Latency: first beat valid one cycle after an accepted start; done pulses the cycle after the final handshake.
// Backpressure: m_data/m_last held while m_valid && !m_ready; the burst advances only on handshake.
module axis_counter_src
    import axis_stream_pkg::*;
#(
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned STEP       = 1,
    parameter int          LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_start_val,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [7:0]            cfg_gap,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beat_cnt
);

    stream_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;

    logic                  hs;
    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic [LEN_WIDTH-1:0]  last_idx;

    assign hs       = valid_q & m_ready;
    assign cnt_inc  = cnt_q + LEN_WIDTH'(1);
    assign last_idx = len_q - LEN_WIDTH'(1);

`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
    logic [7:0] gap_cfg_q, gap_cfg_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
`else
    logic unused_cfg_gap;
    assign unused_cfg_gap = ^cfg_gap;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
        gap_cfg_d = gap_cfg_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    state_d = ST_STREAM;
                    data_d  = cfg_start_val;
                    valid_d = 1'b1;
                    last_d  = (cfg_len == LEN_WIDTH'(1));
                    cnt_d   = '0;
                    len_d   = cfg_len;
`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
                    gap_cfg_d = cfg_gap;
`endif
                end
            end
            ST_STREAM: begin
                if (hs) begin
                    cnt_d  = cnt_inc;
                    // data advances even on the final beat; it is don't-care once valid drops
                    data_d = data_q + DATA_WIDTH'(STEP);
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
                        if (gap_cfg_q != 8'd0) begin
                            state_d   = ST_GAP;
                            valid_d   = 1'b0;
                            last_d    = 1'b0;
                            gap_cnt_d = gap_cfg_q;
                        end else begin
                            last_d = (cnt_inc == last_idx);
                        end
`else
                        last_d = (cnt_inc == last_idx);
`endif
                    end
                end
            end
            ST_GAP: begin
`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
                if (gap_cnt_q == 8'd1) begin
                    state_d = ST_STREAM;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == last_idx);
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
            gap_cfg_q <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
            gap_cfg_q <= gap_cfg_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign m_data   = data_q;
    assign m_valid  = valid_q;
    assign m_last   = last_q;
    assign busy     = (state_q == ST_STREAM) || (state_q == ST_GAP);
    assign done     = (state_q == ST_DONE);
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_axis_counter_src.sv
// Bench for axis_counter_src: randomized bursts checked cycle by cycle against a queue-based burst model.
module tb_axis_counter_src;

    localparam int DW   = 32;
    localparam int LW   = 16;
    localparam int STEP = 1;
`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [DW-1:0] cfg_start_val;
    logic [LW-1:0] cfg_len;
    logic [7:0]    cfg_gap;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic [LW-1:0] beat_cnt;

    always #5 aclk = ~aclk;

    axis_counter_src #(.DATA_WIDTH(DW), .STEP(STEP), .LEN_WIDTH(LW)) u_dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .cfg_start_val (cfg_start_val),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .busy          (busy),
        .done          (done),
        .beat_cnt      (beat_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Burst model: remaining beats as {last,data}, beats accepted, idle cycles owed before next beat.
    logic [DW:0] pend[$];
    bit          active   = 1'b0;
    bit          done_now = 1'b0;
    int          wait_c   = 0;
    int          gap_m    = 0;
    int          beats    = 0;

    // Check outputs mid-cycle, then advance the model across the coming rising edge.
    task automatic tick();
        bit          nd;
        logic [DW:0] b;
        logic [DW-1:0] d;
        @(negedge aclk);
        check_eq("busy", busy, active);
        check_eq("done", done, done_now);
        check_eq("beat_cnt", beat_cnt, beats);
        check_eq("m_valid", m_valid, active && (wait_c == 0));
        if (active && (wait_c == 0)) begin
            check_eq("m_data", m_data, pend[0][DW-1:0]);
            check_eq("m_last", m_last, pend[0][DW]);
        end else begin
            check_eq("m_last_idle", m_last, 1'b0);
        end
        if (areset) begin
            active = 1'b0; pend.delete(); beats = 0; done_now = 1'b0; wait_c = 0;
        end else begin
            nd = 1'b0;
            if (active) begin
                if (wait_c > 0) begin
                    wait_c--;
                end else if (m_ready) begin
                    b = pend.pop_front();
                    beats++;
                    if (b[DW]) begin
                        active = 1'b0;
                        nd = 1'b1;
                    end else begin
                        wait_c = THR ? gap_m : 0;
                    end
                end
            end else if (!done_now && start && (cfg_len != 0)) begin
                active = 1'b1; beats = 0; wait_c = 0; gap_m = int'(cfg_gap);
                for (int k = 0; k < int'(cfg_len); k++) begin
                    d = cfg_start_val + DW'(k) * DW'(STEP);
                    pend.push_back({(k == int'(cfg_len) - 1), d});
                end
            end
            done_now = nd;
        end
        @(posedge aclk);
        #1;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_burst(input logic [DW-1:0] sv, input int len, input int gap,
                             input int mode, input bit poke);
        int n;
        int seen;
        bit fin;
        start = 1'b1; cfg_start_val = sv; cfg_len = LW'(len); cfg_gap = 8'(gap);
        tick();
        start = 1'b0;
        // scramble config after start to show it was sampled
        cfg_start_val = $urandom; cfg_len = LW'($urandom_range(1, 9)); cfg_gap = 8'($urandom_range(0, 3));
        n = 0; seen = -1; fin = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (i % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke && (i == 1 || i == 2);
            tick();
            n++;
            if (done && seen < 0) seen = n;
            if (done_now) fin = 1'b1;
        end
        start = 1'b0;
        check_eq("burst_end", fin, 1'b1);
        // start asserted while the DUT sits in DONE must be ignored
        start = poke;
        tick();
        start = 1'b0;
        if (done && seen < 0) seen = n + 1;
        // cycles counted from the start cycle inclusive
        if (mode == 0 && !THR) check_eq("start_to_done", seen + 1, len + 1);
        tick();
    endtask

    initial begin
        logic [6:0] vpat;
        areset = 1'b1; start = 1'b0; m_ready = 1'b0;
        cfg_start_val = '0; cfg_len = '0; cfg_gap = '0;
        repeat (3) tick();
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_beat_cnt", beat_cnt, 0);
        areset = 1'b0;
        tick();

        run_burst(32'h10, 4, 0, 0, 1'b0);
        check_eq("final_beat_cnt", beat_cnt, 4);
        run_burst(32'h55, 3, 0, 1, 1'b0);
        run_burst(32'hFFFF_FFFE, 4, 0, 0, 1'b0);

        start = 1'b1; cfg_len = '0; cfg_start_val = 32'h1234;
        tick();
        start = 1'b0;
        repeat (3) tick();
        run_burst(32'h200, 5, 0, 0, 1'b1);
        run_burst(32'h300, 1, 0, 0, 1'b1);

        // reset after two accepted beats of an 8-beat burst
        start = 1'b1; cfg_start_val = 32'hA0; cfg_len = 16'd8; cfg_gap = 8'd0;
        tick();
        start = 1'b0; m_ready = 1'b1;
        repeat (2) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_eq("abort_m_valid", m_valid, 0);
        check_eq("abort_m_data", m_data, 0);
        check_eq("abort_beat_cnt", beat_cnt, 0);
        repeat (6) tick();

`ifdef AXIS_COUNTER_SRC_THROTTLE_EN
        start = 1'b1; cfg_start_val = 32'h40; cfg_len = 16'd3; cfg_gap = 8'd2; m_ready = 1'b1;
        tick();
        start = 1'b0;
        vpat = '0;
        for (int j = 0; j < 7; j++) begin
            vpat = {vpat[5:0], m_valid};
            tick();
        end
        check_eq("gap_valid_pattern", vpat, 7'b1001001);
        check_eq("gap_done", done, 1'b1);
        repeat (2) tick();
`else
        vpat = '0;
        check_eq("no_gap_idle", busy, vpat[0]);
`endif

        for (int r = 0; r < 30; r++) begin
            run_burst($urandom, $urandom_range(1, 8), $urandom_range(0, 3), 2,
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; cfg_len = '0;
                tick();
                start = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_counter_src.md
AXIS_COUNTER_SRC -- requirements
Module: axis_counter_src

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of m_data and cfg_start_val.
REQ-002 SHALL have parameter STEP, default 1, increment added between consecutive beats.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of cfg_len and beat_cnt.
REQ-004 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port areset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-007 SHALL have port cfg_start_val  input  DATA_WIDTH  first data value of the burst, sampled with start.
REQ-008 SHALL have port cfg_len  input  LEN_WIDTH  beats in the burst, sampled with start.
REQ-009 SHALL have port cfg_gap  input  8  idle cycles between beats, sampled with start (used only with throttle).
REQ-010 SHALL have port m_data  output  DATA_WIDTH  stream data, registered.
REQ-011 SHALL have port m_valid  output  1  stream valid, registered.
REQ-012 SHALL have port m_last  output  1  marks final beat of the burst.
REQ-013 SHALL have port m_ready  input  1  downstream ready (feeds the stream FIFO s_ready).
REQ-014 SHALL have port busy  output  1  burst in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.
REQ-016 SHALL have port beat_cnt  output  LEN_WIDTH  beats accepted in the current/last burst.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, GAP, DONE.
REQ-018 SHALL, in IDLE, accept start only when cfg_len != 0; start with cfg_len == 0 ignored (no busy, no done).
REQ-019 SHALL, on accepted start at edge N, enter STREAM with m_valid=1, m_data=cfg_start_val, beat_cnt=0 visible after edge N (1-cycle latency).
REQ-020 SHALL count a handshake when m_valid && m_ready at a rising edge; beat_cnt increments by 1 per handshake.
REQ-021 SHALL hold m_data and m_last stable and m_valid high while m_valid && !m_ready.
REQ-022 SHALL produce beat k data = cfg_start_val + k*STEP modulo 2^DATA_WIDTH (wraps silently).
REQ-023 SHALL assert m_last exactly when m_valid is high on beat index cfg_len-1; cfg_len == 1 gives m_last on the first beat.
REQ-024 SHALL, on final handshake, drop m_valid and m_last and enter DONE; done=1 for exactly that one cycle, then IDLE.
REQ-025 SHALL drive busy=1 in STREAM and GAP, 0 in IDLE and DONE.
REQ-026 SHALL ignore start while not in IDLE, including in DONE.
REQ-027 SHALL, without throttle, allow back-to-back beats: with m_ready held high, one beat per cycle, cfg_len+1 cycles from start to done.
REQ-028 SHALL hold beat_cnt at its final value until the next accepted start.

Reset
REQ-029 SHALL, while areset is high at a rising edge, force IDLE, m_valid=0, m_last=0, m_data=0, busy=0, done=0, beat_cnt=0.
REQ-030 SHALL abort a burst on mid-burst reset: m_valid low after that edge, no done pulse, no resumption after release.

Configuration
REQ-031 SHALL support macro AXIS_COUNTER_SRC_THROTTLE_EN.
REQ-032 SHALL, with AXIS_COUNTER_SRC_THROTTLE_EN defined, after each non-final handshake enter GAP with m_valid=0 for the sampled cfg_gap cycles, then return to STREAM with the next value; cfg_gap=0 behaves as back-to-back.
REQ-033 SHALL, without the macro, omit GAP logic; cfg_gap port remains but is ignored.

Structure
REQ-034 SHALL place state encoding (2-bit localparams IDLE/STREAM/GAP/DONE) and default widths in shared package axis_stream_pkg used by stream-path blocks.
REQ-035 SHALL be a single module; optional gap counter inline, no sub-module required.

Verification
REQ-036 SHALL test: start, cfg_start_val=0x10, cfg_len=4, m_ready=1 -> data 0x10,0x11,0x12,0x13 on consecutive cycles, m_last on 0x13, done one cycle later, beat_cnt=4.
REQ-037 SHALL test: cfg_len=3, m_ready toggling 1,0,0,1,... -> m_data/m_last stable during stalls, exactly 3 beats, no duplicates or drops.
REQ-038 SHALL test: cfg_start_val=0xFFFFFFFE, cfg_len=4 -> 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
REQ-039 SHALL test: start with cfg_len=0, and start pulsed mid-burst -> no effect on state, data, or done.
REQ-040 SHALL test: areset after beat 2 of cfg_len=8 -> m_valid=0 next cycle, done never pulses, beat_cnt=0.
REQ-041 SHALL test, throttle build: cfg_gap=2, cfg_len=3, m_ready=1 -> m_valid pattern 1,0,0,1,0,0,1 then done.
